// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator. It steps a (h_cnt, v_cnt) position once per
//   enabled pixel slot and drives registered sync, active-video and
//   pixel-fetch-request strobes. The request leads de by LOOKAHEAD slots, so a
//   pixel source with that many slots of latency lines up with de.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset, has priority over en
//   en           in   pixel slot enable; low stalls the raster
//   hsync/vsync  out  sync strobes, asserted at HS_POL / VS_POL
//   de           out  active video
//   req          out  pixel fetch request, LOOKAHEAD slots ahead of de
//   req_col/row  out  coordinates of the requested pixel, 0 when req=0
//   line_start   out  one-clock pulse for the slot at h_cnt=0
//   frame_start  out  one-clock pulse for the slot at (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_SYNC    = 40,
    parameter int H_BP      = 220,
    parameter int H_ACTIVE  = 1280,
    parameter int H_FP      = 110,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 20,
    parameter int V_ACTIVE  = 720,
    parameter int V_FP      = 5,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int LOOKAHEAD = 2,
    parameter int CW        = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          req,
    output logic [CW-1:0] req_col,
    output logic [CW-1:0] req_row,
    output logic          line_start,
    output logic          frame_start
);

    localparam int HT    = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int VT    = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_DE0 = H_SYNC + H_BP;
    localparam int H_DE1 = H_DE0 + H_ACTIVE;
    localparam int V_DE0 = V_SYNC + V_BP;
    localparam int V_DE1 = V_DE0 + V_ACTIVE;

    if (LOOKAHEAD < 0 || LOOKAHEAD > H_DE0 || HT >= (1 << CW) || VT >= (1 << CW)) begin : g_bad_params
        $error("vga_timing_gen: illegal LOOKAHEAD or counter width too small");
    end

    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic          hsync_q, vsync_q, de_q, req_q, ls_q, fs_q;
    logic [CW-1:0] col_q, row_q;

    // Next-position and next-output values for the current slot
    logic          hsync_d, vsync_d, de_d, req_d, ls_d, fs_d, v_act;
    logic [CW-1:0] col_d, row_d;
    logic [CW:0]   hla;   // one extra bit so h+LOOKAHEAD never wraps into the window

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (en) begin
            if (h_q == CW'(HT - 1)) begin
                h_d = '0;
                v_d = (v_q == CW'(VT - 1)) ? '0 : v_q + CW'(1);
            end else begin
                h_d = h_q + CW'(1);
            end
        end
    end

    always_comb begin
        hla     = {1'b0, h_q} + (CW+1)'(LOOKAHEAD);
        v_act   = (v_q >= CW'(V_DE0)) && (v_q < CW'(V_DE1));
        hsync_d = (h_q < CW'(H_SYNC)) ? HS_POL : ~HS_POL;
        vsync_d = (v_q < CW'(V_SYNC)) ? VS_POL : ~VS_POL;
        de_d    = v_act && (h_q >= CW'(H_DE0)) && (h_q < CW'(H_DE1));
        req_d   = v_act && (hla >= (CW+1)'(H_DE0)) && (hla < (CW+1)'(H_DE1));
        col_d   = req_d ? CW'(hla - (CW+1)'(H_DE0)) : '0;
        row_d   = req_d ? (v_q - CW'(V_DE0)) : '0;
        ls_d    = (h_q == '0);
        fs_d    = (h_q == '0) && (v_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            req_q   <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
            if (en) begin
                hsync_q <= hsync_d;
                vsync_q <= vsync_d;
                de_q    <= de_d;
                req_q   <= req_d;
                col_q   <= col_d;
                row_q   <= row_d;
                ls_q    <= ls_d;
                fs_q    <= fs_d;
            end else begin
                // Levels hold through a stall; pulses must not repeat
                ls_q <= 1'b0;
                fs_q <= 1'b0;
            end
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign req         = req_q;
    assign req_col     = col_q;
    assign req_row     = row_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Drives reset/enable patterns into two small-raster instances (sync
//   polarity 0 and 1) and compares every output each clock against a model
//   that derives the raster position from the number of enabled slots since
//   reset (position = slots mod frame size), then applies the window rules.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int HT = 15, VT = 7, FT = HT * VT;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst, en;

    logic a_hs, a_vs, a_de, a_req, a_ls, a_fs;
    logic b_hs, b_vs, b_de, b_req, b_ls, b_fs;
    logic [CW-1:0] a_col, a_row, b_col, b_row;

    vga_timing_gen #(.H_SYNC(2), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
                     .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
                     .HS_POL(1'b0), .VS_POL(1'b0), .LOOKAHEAD(2), .CW(CW)) dut_a (
        .clk(clk), .rst(rst), .en(en),
        .hsync(a_hs), .vsync(a_vs), .de(a_de), .req(a_req),
        .req_col(a_col), .req_row(a_row),
        .line_start(a_ls), .frame_start(a_fs));

    vga_timing_gen #(.H_SYNC(2), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
                     .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
                     .HS_POL(1'b1), .VS_POL(1'b1), .LOOKAHEAD(2), .CW(CW)) dut_b (
        .clk(clk), .rst(rst), .en(en),
        .hsync(b_hs), .vsync(b_vs), .de(b_de), .req(b_req),
        .req_col(b_col), .req_row(b_row),
        .line_start(b_ls), .frame_start(b_fs));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference state: slots counted since reset, expected (polarity-0) outputs
    longint slots;
    logic   e_hs, e_vs, e_de, e_req, e_ls, e_fs;
    int     e_col, e_row;

    // Period bookkeeping on observed pulses
    int cyc = 0, last_fs = -1, last_ls = -1, de_cnt = 0;
    int fs_period = 0, ls_period = 0;
    bit de_chk = 0;

    task automatic model_slot();
        int pos, h, v, hr;
        pos   = int'(slots % FT);
        h     = pos % HT;
        v     = pos / HT;
        hr    = h + 2;
        e_hs  = !(h < 2);
        e_vs  = !(v < 1);
        e_de  = (h >= 5 && h < 13) && (v >= 2 && v < 6);
        e_req = (hr >= 5 && hr < 13) && (v >= 2 && v < 6);
        e_col = e_req ? hr - 5 : 0;
        e_row = e_req ? v - 2 : 0;
        e_ls  = (h == 0);
        e_fs  = (pos == 0);
        slots++;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst) begin
            slots = 0;
            e_hs = 1; e_vs = 1; e_de = 0; e_req = 0;
            e_col = 0; e_row = 0; e_ls = 0; e_fs = 0;
        end else if (en) begin
            model_slot();
        end else begin
            e_ls = 0;
            e_fs = 0;
        end
        #1;
        chk("hsync",  a_hs,  e_hs);
        chk("vsync",  a_vs,  e_vs);
        chk("de",     a_de,  e_de);
        chk("req",    a_req, e_req);
        chk("col",    a_col, e_col);
        chk("row",    a_row, e_row);
        chk("ls",     a_ls,  e_ls);
        chk("fs",     a_fs,  e_fs);
        chk("hsync_p1", b_hs, !e_hs);
        chk("vsync_p1", b_vs, !e_vs);
        chk("de_p1",    b_de, e_de);
        chk("fs_p1",    b_fs, e_fs);
        if (rst) begin
            last_fs = -1;
            last_ls = -1;
        end
        if (a_ls) begin
            if (ls_period != 0 && last_ls >= 0) chk("ls_period", cyc - last_ls, ls_period);
            last_ls = cyc;
        end
        if (a_fs) begin
            if (fs_period != 0 && last_fs >= 0) chk("fs_period", cyc - last_fs, fs_period);
            if (de_chk && last_fs >= 0) chk("de_per_frame", de_cnt, 32);
            last_fs = cyc;
            de_cnt  = 0;
        end
        if (a_de) de_cnt++;
    endtask

    task automatic new_phase(input int fsp, input int lsp, input bit dechk);
        fs_period = fsp;
        ls_period = lsp;
        de_chk    = dechk;
        last_fs   = -1;
        last_ls   = -1;
    endtask

    initial begin
        slots = 0;
        rst = 1'b1;
        en  = 1'b0;
        new_phase(0, 0, 0);
        step();
        step();

        // Constant enable: 105-clock frames, 15-clock lines, 32 de clocks
        rst = 1'b0;
        en  = 1'b1;
        new_phase(FT, HT, 1);
        repeat (4 * FT) step();

        // Alternating enable: periods double, pulses stay one clock wide
        new_phase(2 * FT, 2 * HT, 0);
        for (int i = 0; i < 5 * 2 * FT; i++) begin
            en = (i % 2 == 0);
            step();
        end

        // Reset while the counters sit at (7,3), then the first slot is a frame start
        en = 1'b1;
        new_phase(0, 0, 0);
        for (int i = 0; i < 2 * FT && (slots % FT) != 3 * HT + 7; i++) step();
        chk("reach_7_3", int'(slots % FT), 3 * HT + 7);
        rst = 1'b1;
        step();
        chk("rst_de", a_de, 0);
        chk("rst_req", a_req, 0);
        rst = 1'b0;
        step();
        chk("post_rst_fs", a_fs, 1);
        chk("post_rst_hs", a_hs, 0);

        // Random enable with occasional reset
        for (int i = 0; i < 1500; i++) begin
            en  = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
